// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide unit that owns the HI/LO registers.
// It runs one mult/multu/div/divu at a time, retiring one bit per cycle over
// WIDTH cycles. mthi/mtlo write HI/LO directly while the unit is idle.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start           issue strobe; op/funct/da/db are sampled with it
//   op, funct       instruction opcode and function fields; only op==0 is decoded
//   da, db          rs and rt operands
//   hilo_rd         the CPU is reading HI or LO (mfhi/mflo) this cycle
//   busy, stall     unit occupied; stall holds the CPU while a new op or read waits
//   done            one-cycle pulse when a mult/div result lands in HI/LO
//   hi, lo          architectural HI/LO registers
module muldiv_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [5:0]       op,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] da,
   input  logic [WIDTH-1:0] db,
   input  logic             hilo_rd,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned PW = 2 * WIDTH;

   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   logic [1:0]       state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [PW-1:0]    acc;      // multiply: product/multiplier; divide: low half is dividend/quotient
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] mcand;    // multiplicand or divisor magnitude
   logic             is_div, neg_q, neg_r, div0;

   // Issue decode
   logic             sel, is_mul_op, is_div_op, is_signed, sa, sb;
   logic [WIDTH-1:0] mag_a, mag_b;

   assign sel       = start && (op == 6'd0) && (state == S_IDLE);
   assign is_mul_op = (funct == F_MULT) || (funct == F_MULTU);
   assign is_div_op = (funct == F_DIV)  || (funct == F_DIVU);
   assign is_signed = (funct == F_MULT) || (funct == F_DIV);
   assign sa        = is_signed && da[WIDTH-1];
   assign sb        = is_signed && db[WIDTH-1];
   // 0x80..0 negates to itself, which reads correctly as the unsigned magnitude 2^(WIDTH-1)
   assign mag_a     = sa ? (~da + WIDTH'(1)) : da;
   assign mag_b     = sb ? (~db + WIDTH'(1)) : db;

   assign busy  = (state != S_IDLE);
   assign stall = busy && (start || hilo_rd);

   // Multiply step: conditionally add the multiplicand to the upper half, then shift right
   logic [WIDTH:0]   msum;
   logic [PW-1:0]    mul_nxt;
   assign msum    = {1'b0, acc[PW-1:WIDTH]} + {1'b0, (acc[0] ? mcand : '0)};
   assign mul_nxt = {msum, acc[WIDTH-1:1]};

   // Restoring divide step; the borrow bit of the trial subtraction decides the quotient bit
   logic [WIDTH:0]   shifted, diff;
   logic             ge;
   assign shifted = {rem, acc[WIDTH-1]};
   assign diff    = shifted - {1'b0, mcand};
   assign ge      = ~diff[WIDTH];

   // Final sign fix-up
   logic [PW-1:0]    prod_fix;
   logic [WIDTH-1:0] q_fix, r_fix;
   assign prod_fix = neg_q ? (~acc + PW'(1)) : acc;
   assign q_fix    = div0 ? '1 : (neg_q ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0]);
   assign r_fix    = neg_r ? (~rem + WIDTH'(1)) : rem;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (sel && (is_mul_op || is_div_op)) state_nxt = S_RUN;
         S_RUN:   if (cnt == CW'(WIDTH - 1)) state_nxt = S_FIX;
         S_FIX:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath and HI/LO registers
   always_ff @(posedge clk) begin
      if (rst) begin
         hi   <= '0;
         lo   <= '0;
         done <= 1'b0;
         cnt  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (sel && (is_mul_op || is_div_op)) begin
                  is_div <= is_div_op;
                  neg_q  <= sa ^ sb;
                  neg_r  <= sa;
                  div0   <= (db == '0);
                  cnt    <= '0;
                  rem    <= '0;
                  acc    <= {{WIDTH{1'b0}}, (is_div_op ? mag_a : mag_b)};
                  mcand  <= is_div_op ? mag_b : mag_a;
               end else if (sel && (funct == F_MTHI)) begin
                  hi <= da;
               end else if (sel && (funct == F_MTLO)) begin
                  lo <= da;
               end
            end
            S_RUN: begin
               cnt <= cnt + CW'(1);
               if (is_div) begin
                  rem <= ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                  acc <= {acc[PW-1:WIDTH], acc[WIDTH-2:0], ge};
               end else begin
                  acc <= mul_nxt;
               end
            end
            S_FIX: begin
               done <= 1'b1;
               if (is_div) begin
                  hi <= r_fix;
                  lo <= q_fix;
               end else begin
                  hi <= prod_fix[PW-1:WIDTH];
                  lo <= prod_fix[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed bench for muldiv_seq with hand-computed HI/LO results,
// latency, stall behaviour, ignored issues and mid-operation reset.
module tb_muldiv_seq;

   localparam int unsigned W = 32;

   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [5:0]   op = '0;
   logic [5:0]   funct = '0;
   logic [W-1:0] da = '0;
   logic [W-1:0] db = '0;
   logic         hilo_rd = 1'b0;
   logic         busy, stall, done;
   logic [W-1:0] hi, lo;

   int           n_assert = 0;
   int           n_fail = 0;
   logic [W-1:0] e_hi = '0;
   logic [W-1:0] e_lo = '0;

   muldiv_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .funct(funct),
      .da(da), .db(db), .hilo_rd(hilo_rd),
      .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [5:0] o, input logic [5:0] f,
                        input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      op = o; funct = f; da = a; db = b; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic run_md(input string tag, input logic [5:0] f,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eh, input logic [W-1:0] el);
      int nb;
      issue(6'd0, f, a, b);
      nb = 0;
      for (int i = 0; i < 40 && busy; i++) begin
         nb++;
         if (i == 16) begin
            check({tag, " hold hi"}, hi, e_hi);
            check({tag, " hold lo"}, lo, e_lo);
            check({tag, " done mid"}, 32'(done), 32'd0);
         end
         @(posedge clk);
         #1;
      end
      check({tag, " busy cycles"}, 32'(nb), 32'd33);
      check({tag, " done"}, 32'(done), 32'd1);
      check({tag, " hi"}, hi, eh);
      check({tag, " lo"}, lo, el);
      e_hi = eh;
      e_lo = el;
      @(posedge clk);
      #1;
      check({tag, " done drop"}, 32'(done), 32'd0);
   endtask

   initial begin
      int nb, ns, nd;

      // Reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst busy", 32'(busy), 32'd0);
      check("rst stall", 32'(stall), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst hi", hi, 32'd0);
      check("rst lo", lo, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // mthi / mtlo in idle
      issue(6'd0, F_MTHI, 32'd5, 32'd0);
      check("mthi hi", hi, 32'd5);
      check("mthi lo", lo, 32'd0);
      check("mthi busy", 32'(busy), 32'd0);
      issue(6'd0, F_MTLO, 32'd6, 32'd0);
      check("mtlo lo", lo, 32'd6);
      check("mtlo hi", hi, 32'd5);
      check("mtlo busy", 32'(busy), 32'd0);
      check("mtlo done", 32'(done), 32'd0);
      e_hi = 32'd5;
      e_lo = 32'd6;

      // Non-zero opcode and unrelated funct have no effect
      issue(6'h01, F_MULT, 32'd3, 32'd3);
      check("op!=0 busy", 32'(busy), 32'd0);
      issue(6'd0, 6'h20, 32'd9, 32'd9);
      check("add busy", 32'(busy), 32'd0);
      check("add hi", hi, 32'd5);
      check("add lo", lo, 32'd6);

      // mfhi/mflo while idle never stalls
      @(negedge clk);
      hilo_rd = 1'b1;
      #1;
      check("idle hilo_rd stall", 32'(stall), 32'd0);
      hilo_rd = 1'b0;

      // Arithmetic vectors
      run_md("multu max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_md("mult -3*7", F_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_md("mult min*min", F_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
      run_md("mult 6*7", F_MULT,   32'd6,         32'd7,         32'h0,         32'd42);
      run_md("div -7/2", F_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_md("divu 7/2", F_DIVU,   32'd7,         32'd2,         32'd1,         32'd3);
      run_md("div 7/-2", F_DIV,    32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
      run_md("div ovf", F_DIV,     32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);
      run_md("divu by0", F_DIVU,   32'h1234,      32'h0,         32'h1234,      32'hFFFF_FFFF);
      run_md("div -7/0", F_DIV,    32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);

      // A second start while running is ignored and raises stall
      issue(6'd0, F_DIVU, 32'd7, 32'd2);
      nb = 0;
      for (int i = 0; i < 40 && busy; i++) begin
         nb++;
         if (i == 4) begin
            @(negedge clk);
            funct = F_MTLO; da = 32'hDEAD_BEEF; start = 1'b1;
            #1;
            check("busy start stall", 32'(stall), 32'd1);
         end
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      check("ignored start busy cycles", 32'(nb), 32'd33);
      check("ignored start done", 32'(done), 32'd1);
      check("ignored start lo", lo, 32'd3);
      check("ignored start hi", hi, 32'd1);

      // Reading HI/LO during an operation stalls until the result lands
      issue(6'd0, F_MULT, 32'd6, 32'd7);
      hilo_rd = 1'b1;
      nb = 0;
      ns = 0;
      for (int i = 0; i < 40 && busy; i++) begin
         nb++;
         if (stall) ns++;
         @(posedge clk);
         #1;
      end
      check("hilo_rd stall cycles", 32'(ns), 32'd33);
      check("hilo_rd done stall", 32'(stall), 32'd0);
      check("hilo_rd done", 32'(done), 32'd1);
      check("hilo_rd lo", lo, 32'd42);
      hilo_rd = 1'b0;

      // Reset in the middle of an operation discards it
      issue(6'd0, F_MULTU, 32'hFFFF_FFFF, 32'd2);
      repeat (9) @(posedge clk);
      @(negedge clk);
      check("pre-rst busy", 32'(busy), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("mid rst busy", 32'(busy), 32'd0);
      check("mid rst hi", hi, 32'd0);
      check("mid rst lo", lo, 32'd0);
      check("mid rst done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done) nd++;
      end
      check("post rst done pulses", 32'(nd), 32'd0);
      check("post rst hi", hi, 32'd0);
      check("post rst lo", lo, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
